// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed UART transmitter (start bit, LSB-first data, one stop bit)
module uart_tx #(
    parameter int DataBitsSize = 8,
    parameter int ClksPerBit   = 434
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tx_en,
    input  logic [DataBitsSize-1:0] fifo_q,
    input  logic                    fifo_empty,
    output logic                    fifo_read_ack,
    output logic                    tx,
    output logic                    busy
);
    localparam int CW = $clog2(ClksPerBit);
    localparam int BW = (DataBitsSize > 1) ? $clog2(DataBitsSize) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(ClksPerBit - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DataBitsSize - 1);
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
    state_t                  state_q, state_d;
    logic [CW-1:0]           baud_q, baud_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [DataBitsSize-1:0] shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    baud_done, can_start;
    assign baud_done     = baud_q == BAUD_LAST;
    assign can_start     = tx_en && !fifo_empty;
    assign fifo_read_ack = state_q == LOAD;
    assign busy          = state_q != IDLE;
    assign tx            = tx_q;
    // Next state, counters and shift register; tx is precomputed from the next state so it leaves a flop
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE:  state_d = can_start ? LOAD : IDLE;
            LOAD: begin
                state_d = START;
                shift_d = fifo_q;
            end
            START: begin
                baud_d  = baud_done ? '0 : baud_q + 1'b1;
                bit_d   = '0;
                state_d = baud_done ? DATA : START;
            end
            DATA: begin
                baud_d = baud_done ? '0 : baud_q + 1'b1;
                if (baud_done) begin
                    shift_d = shift_q >> 1;
                    bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
                    state_d = (bit_q == BIT_LAST) ? STOP : DATA;
                end
            end
            STOP: begin
                baud_d  = baud_done ? '0 : baud_q + 1'b1;
                state_d = !baud_done ? STOP : can_start ? LOAD : IDLE;
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    end
    // State register; reset drops any frame in flight and returns the line to idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with ClksPerBit=4
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b1;
    logic [7:0] fifo_q = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       fifo_read_ack, tx, busy;
    logic [7:0] q[$];
    logic       txlog [0:1023];
    int         n, busy_cnt, ack_cnt, ack_empty_bad, checks, errors;

    uart_tx #(.DataBitsSize(8), .ClksPerBit(4)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
        .fifo_read_ack(fifo_read_ack), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic fifo_upd();
        fifo_empty = (q.size() == 0);
        fifo_q = fifo_empty ? 8'h00 : q[0];
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        fifo_upd();
    endtask

    task automatic clr();
        n = 0;
        busy_cnt = 0;
        ack_cnt = 0;
    endtask

    task automatic cyc();
        logic ack_pre;
        ack_pre = fifo_read_ack;
        @(posedge clk);
        #1;
        if (ack_pre === 1'b1 && q.size() > 0) void'(q.pop_front());
        fifo_upd();
        if (n < 1024) txlog[n] = tx;
        n++;
        busy_cnt += int'(busy);
        ack_cnt += int'(fifo_read_ack);
        if (fifo_read_ack && fifo_empty) ack_empty_bad++;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cyc();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] frame_wave(input logic [7:0] b);
        logic [9:0]  bits;
        logic [39:0] w;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) w[i] = bits[i/4];
        return w;
    endfunction

    task automatic chk_frame(input string tag, input int start, input logic [7:0] b);
        logic [39:0] obs;
        for (int i = 0; i < 40; i++) obs[i] = txlog[start+i];
        chk(tag, {24'h0, obs}, {24'h0, frame_wave(b)});
    endtask

    function automatic int zeros(input int a, input int b);
        int z = 0;
        for (int i = a; i <= b; i++) z += int'(txlog[i] !== 1'b1);
        return z;
    endfunction

    initial begin
        checks = 0; errors = 0; ack_empty_bad = 0;
        clr();
        run(3);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ack", fifo_read_ack, 0);
        // idle with empty FIFO
        rst = 1'b0;
        clr();
        run(100);
        chk("idle_busy", busy_cnt, 0);
        chk("idle_ack", ack_cnt, 0);
        chk("idle_tx_low", zeros(0, 99), 0);
        // single frame 0xA5
        clr();
        push(8'hA5);
        run(50);
        chk("a5_load_tx", txlog[0], 1);
        chk_frame("a5_frame", 1, 8'hA5);
        chk("a5_busy", busy_cnt, 41);
        chk("a5_ack", ack_cnt, 1);
        chk("a5_idle_after", txlog[41], 1);
        // back-to-back frames
        clr();
        push(8'h00); push(8'hFF); push(8'h3C);
        run(130);
        chk_frame("b2b_f0", 1, 8'h00);
        chk("b2b_gap1", txlog[41], 1);
        chk_frame("b2b_f1", 42, 8'hFF);
        chk("b2b_gap2", txlog[82], 1);
        chk_frame("b2b_f2", 83, 8'h3C);
        chk("b2b_ack", ack_cnt, 3);
        chk("b2b_busy", busy_cnt, 123);
        chk("b2b_fifo_left", q.size(), 0);
        // tx_en gating
        tx_en = 1'b0;
        clr();
        push(8'h55);
        run(20);
        chk("gate_ack", ack_cnt, 0);
        chk("gate_busy", busy_cnt, 0);
        chk("gate_tx_low", zeros(0, 19), 0);
        tx_en = 1'b1;
        clr();
        run(50);
        chk("gate_load_tx", txlog[0], 1);
        chk_frame("gate_frame", 1, 8'h55);
        chk("gate_ack_after", ack_cnt, 1);
        // reset during DATA bit 3 of 0x81
        clr();
        push(8'h81);
        run(18);
        chk("rstmid_bit3_tx", txlog[17], 0);
        chk("rstmid_busy_pre", busy, 1);
        rst = 1'b1;
        cyc();
        chk("rstmid_tx", tx, 1);
        chk("rstmid_busy", busy, 0);
        rst = 1'b0;
        clr();
        run(60);
        chk("rstmid_no_busy", busy_cnt, 0);
        chk("rstmid_no_ack", ack_cnt, 0);
        chk("rstmid_tx_low", zeros(0, 59), 0);
        // tx_en dropped during START with a second byte queued
        clr();
        push(8'h12); push(8'h34);
        run(2);
        tx_en = 1'b0;
        run(58);
        chk_frame("drop_frame", 1, 8'h12);
        chk("drop_ack", ack_cnt, 1);
        chk("drop_busy", busy_cnt, 41);
        chk("drop_queued", q.size(), 1);
        tx_en = 1'b1;
        clr();
        run(50);
        chk("resume_load_tx", txlog[0], 1);
        chk_frame("resume_frame", 1, 8'h34);
        chk("resume_ack", ack_cnt, 1);
        chk("resume_fifo_left", q.size(), 0);
        chk("ack_while_empty", ack_empty_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DataBitsSize, default 8, data bits per frame; equals the width of the feeding FIFO.
REQ-002 SHALL have parameter ClksPerBit, default 434, clock cycles per UART bit (50 MHz / 115200); legal range is >= 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port tx_en, input, 1, permits starting a new frame.
REQ-006 SHALL have port fifo_q, input, DataBitsSize, head-of-FIFO data (registered FIFO output).
REQ-007 SHALL have port fifo_empty, input, 1, FIFO empty flag.
REQ-008 SHALL have port fifo_read_ack, output, 1, one-cycle pop strobe to the FIFO.
REQ-009 SHALL have port tx, output, 1, serial line; idles high.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, START, DATA, STOP.
REQ-012 IDLE: tx=1, busy=0; if tx_en=1 and fifo_empty=0 at a clock edge, next state LOAD; otherwise stay in IDLE.
REQ-013 LOAD lasts exactly 1 cycle; fifo_read_ack=1 only in LOAD; at the end of LOAD the shift register latches fifo_q; next state START.
REQ-014 fifo_read_ack SHALL be a Moore output of state LOAD only; it is never asserted in any other state and never asserted while fifo_empty=1.
REQ-015 START: tx=0 for ClksPerBit cycles, then DATA.
REQ-016 DATA: DataBitsSize bits, LSB first, each held ClksPerBit cycles; shift right after each bit; bit counter width $clog2(DataBitsSize).
REQ-017 STOP: tx=1 for ClksPerBit cycles, then re-evaluate the IDLE condition in the same edge: go to LOAD if tx_en=1 and fifo_empty=0, else IDLE.
REQ-018 Back-to-back frames SHALL have no idle gap: the next frame's LOAD cycle follows STOP directly, and the frame period is 10*ClksPerBit+1 cycles for DataBitsSize=8.
REQ-019 The baud counter SHALL be $clog2(ClksPerBit) bits wide, count 0..ClksPerBit-1, and reset to 0 on every state or bit transition; there is no wrap beyond ClksPerBit-1.
REQ-020 Latency: if fifo_empty is first low in cycle c (state IDLE, tx_en=1), LOAD occurs in cycle c+1 and tx falls in cycle c+2.
REQ-021 tx SHALL be driven from a register, with no combinational glitch path.
REQ-022 tx_en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next LOAD.
REQ-023 fifo_q SHALL be sampled only at the end of LOAD; changes of fifo_q at any other time have no effect.

Reset
REQ-024 With rst=1 at a clock edge: state=IDLE, tx=1, busy=0, fifo_read_ack=0, baud and bit counters=0, shift register=0.
REQ-025 Reset mid-frame (any state) SHALL abort the frame; tx is high from the cycle after the edge; the aborted byte is lost and is not re-read.
REQ-026 Reset has priority over all other inputs.

Verification (ClksPerBit=4, DataBitsSize=8)
REQ-027 Reset, FIFO empty, tx_en=1 for 100 cycles -> tx=1, busy=0, fifo_read_ack never high.
REQ-028 Push 0xA5 into the FIFO -> exactly 1 fifo_read_ack pulse; tx = 0, 1,0,1,0,0,1,0,1, 1, each level held 4 cycles; busy high for 41 cycles.
REQ-029 Push 0x00, 0xFF, 0x3C back-to-back -> 3 frames with a 1-cycle LOAD between them at tx=1 (the STOP level held), 3 acks total, data bits correct LSB first.
REQ-030 tx_en=0 with FIFO holding 0x55 -> no ack and tx=1; raise tx_en -> frame starts with tx falling 2 cycles later.
REQ-031 Assert rst in DATA bit 3 of 0x81 -> tx=1 the next cycle, busy=0; after release with FIFO empty no further frame is sent.
REQ-032 Drop tx_en during START of 0x12 with a second byte queued -> 0x12 completes fully, the second byte is not acked until tx_en returns high.
